// File: rtl/cpa_seg_seq.sv
// cpa_seg_seq: DATA_W-bit adder sequenced one SEG_W-bit segment per cycle through an external narrow CPA.
// Inter-segment carry enters via bit 0 of both CPA operands, since the CPA has no carry-in.
module cpa_seg_seq #(
  parameter int SEG_W = 5,
  parameter int NUM_SEG = 4,
  localparam int DATA_W = SEG_W * NUM_SEG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_cout,
  output logic [SEG_W:0]    cpa_a,
  output logic [SEG_W:0]    cpa_b,
  input  logic [SEG_W:0]    cpa_sum,
  input  logic              cpa_cout,
  output logic              busy,
  output logic              err
);
  localparam int KW = $clog2(NUM_SEG);
  localparam logic [KW-1:0] K_LAST = KW'(NUM_SEG - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [DATA_W-1:0] r_a, r_b, r_sum;
  logic [KW-1:0] r_k;
  logic r_c, r_cout, r_err;
  logic w_last;
  assign w_last = r_k == K_LAST;
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (in_valid ? RUN : IDLE) :
             (r_state == RUN)  ? (w_last ? DONE : RUN) :
             (out_ready ? IDLE : DONE);
  end
  assign in_ready  = (r_state == IDLE) & ~rst;
  assign busy      = r_state == RUN;
  assign out_valid = r_state == DONE;
  assign cpa_a     = busy ? {r_a[int'(r_k)*SEG_W +: SEG_W], r_c} : '0;
  assign cpa_b     = busy ? {r_b[int'(r_k)*SEG_W +: SEG_W], r_c} : '0;
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;
  assign err       = r_err;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k    <= '0;
      r_c    <= 1'b0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_err  <= 1'b0;
    end else if (in_ready & in_valid) begin
      r_a <= in_a;
      r_b <= in_b;
      r_c <= in_cin;
      r_k <= '0;
    end else if (busy) begin
      r_sum[int'(r_k)*SEG_W +: SEG_W] <= cpa_sum[SEG_W:1];
      r_c   <= cpa_cout;
      r_k   <= r_k + 1'b1;
      r_err <= r_err | cpa_sum[0];
      if (w_last) r_cout <= cpa_cout;
    end
  end
endmodule

// File: tb/tb_cpa_seg_seq.sv
// tb_cpa_seg_seq: directed table, back-pressure, reset, fault and random checks of cpa_seg_seq.
module tb_cpa_seg_seq;
  localparam int SEG_W = 5;
  localparam int NUM_SEG = 4;
  localparam int DATA_W = SEG_W * NUM_SEG;
  logic clk = 0, rst = 1, in_valid = 0, in_cin = 0, out_ready = 1, inj = 0;
  logic [DATA_W-1:0] in_a = '0, in_b = '0, out_sum;
  logic [SEG_W:0] cpa_a, cpa_b, cpa_sum;
  logic cpa_cout, in_ready, out_valid, out_cout, busy, err;
  cpa_seg_seq #(.SEG_W(SEG_W), .NUM_SEG(NUM_SEG)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
    .cpa_a(cpa_a), .cpa_b(cpa_b), .cpa_sum(cpa_sum), .cpa_cout(cpa_cout),
    .busy(busy), .err(err)
  );
  // behavioural narrow CPA; inj corrupts sum bit 0 to exercise the error flag
  assign {cpa_cout, cpa_sum} = ({1'b0, cpa_a} + {1'b0, cpa_b}) | {{(SEG_W+1){1'b0}}, inj};
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  int busy_cnt = 0, c1_cnt = 0;
  always @(negedge clk) if (busy) begin
    busy_cnt++;
    if (cpa_a[0] && cpa_b[0]) c1_cnt++;
  end
  int checks = 0, errors = 0, t_acc = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [DATA_W:0] ref_add(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic cin);
    return {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
  endfunction
  // number of segments whose incoming carry is 1, from the partial sums of the low bits
  function automatic int ref_c1(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic cin);
    int n = 0;
    for (int k = 0; k < NUM_SEG; k++) begin
      longint m = (longint'(1) << (k * SEG_W)) - 1;
      longint s = (longint'(a) & m) + (longint'(b) & m) + longint'(cin);
      n += int'((s >> (k * SEG_W)) & 1);
    end
    return n;
  endfunction
  task automatic start_op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic cin);
    int w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    chk("in_ready_before_accept", in_ready, 1);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1;
    @(posedge clk);
    busy_cnt = 0; c1_cnt = 0;
    #1;
    t_acc = cyc;
    in_valid = 0; in_a = DATA_W'($urandom); in_b = DATA_W'($urandom); in_cin = 1'($urandom);
  endtask
  task automatic finish_op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic cin, input int hold);
    logic [DATA_W:0] r = ref_add(a, b, cin);
    int w = 0;
    while (!out_valid && w < 50) begin
      chk("in_ready_while_busy", in_ready, 0);
      @(posedge clk); #1; w++;
    end
    chk("out_valid_seen", out_valid, 1);
    chk("latency", cyc - t_acc, NUM_SEG);
    chk("busy_cycles", busy_cnt, NUM_SEG);
    chk("carry_pad_cycles", c1_cnt, ref_c1(a, b, cin));
    chk("sum", out_sum, r[DATA_W-1:0]);
    chk("cout", out_cout, r[DATA_W]);
    out_ready = 0;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom); in_a = DATA_W'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_sum", out_sum, r[DATA_W-1:0]);
      chk("hold_cout", out_cout, r[DATA_W]);
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    chk("idle_after_handshake", in_ready, 1);
    chk("valid_drop", out_valid, 0);
  endtask
  task automatic do_op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic cin, input int hold);
    start_op(a, b, cin);
    finish_op(a, b, cin, hold);
  endtask
  typedef struct {
    logic [DATA_W-1:0] a, b;
    logic cin;
    logic [DATA_W-1:0] sum;
    logic cout;
  } vec_t;
  vec_t tbl[6];
  initial begin
    tbl[0] = '{20'h00001, 20'h00002, 1'b0, 20'h00003, 1'b0};
    tbl[1] = '{20'hFFFFF, 20'h00000, 1'b1, 20'h00000, 1'b1};
    tbl[2] = '{20'hFFFFF, 20'hFFFFF, 1'b1, 20'hFFFFF, 1'b1};
    tbl[3] = '{20'h0F0F0, 20'h10F10, 1'b0, 20'h20000, 1'b0};
    tbl[4] = '{20'h12345, 20'h54321, 1'b1, 20'h66667, 1'b0};
    tbl[5] = '{20'h80000, 20'h80000, 1'b0, 20'h00000, 1'b1};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", out_sum, 0);
    chk("rst_cout", out_cout, 0);
    chk("rst_err", err, 0);
    chk("rst_cpa_a", cpa_a, 0);
    rst = 0;
    #1;
    chk("idle_in_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      start_op(tbl[i].a, tbl[i].b, tbl[i].cin);
      finish_op(tbl[i].a, tbl[i].b, tbl[i].cin, 0);
      chk("table_sum", out_sum, tbl[i].sum);
      chk("table_cout", out_cout, tbl[i].cout);
    end
    do_op(20'hABCDE, 20'h13579, 1'b1, 10);
    do_op(20'h00FFF, 20'h00001, 1'b0, 0);
    start_op(20'h12345, 20'h0ABCD, 1'b0);
    @(posedge clk); #1;
    chk("second_run_cycle_busy", busy, 1);
    rst = 1;
    @(posedge clk); #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_sum", out_sum, 0);
    chk("midrst_in_ready", in_ready, 0);
    rst = 0;
    #1;
    do_op(20'h12345, 20'h0ABCD, 1'b0, 0);
    chk("err_clear_before_fault", err, 0);
    start_op(20'h3C3C3, 20'h0F0F0, 1'b1);
    inj = 1;
    @(posedge clk); #1;
    inj = 0;
    chk("err_set", err, 1);
    finish_op(20'h3C3C3, 20'h0F0F0, 1'b1, 0);
    do_op(20'h00010, 20'h00020, 1'b0, 1);
    chk("err_sticky", err, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("err_cleared_by_rst", err, 0);
    for (int i = 0; i < 1000; i++)
      do_op(DATA_W'($urandom), DATA_W'($urandom), 1'($urandom), $urandom_range(0, 2));
    chk("err_after_random", err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
